// File: rtl/d_sync_counter_pkg.sv
// Shared constants for the synchronous D flip-flop counter.
package d_sync_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam bit UP            = 1'b1;
    localparam bit DOWN          = 1'b0;

endpackage

// File: rtl/d_sync_counter_d_ff.sv
// Single D flip-flop with asynchronous active-low reset and complemented output.
module d_ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic qbar
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

    assign qbar = ~q;

endmodule

// File: rtl/d_sync_counter.sv
// Free-running synchronous modulo counter: WIDTH D flip-flops on one clock,
// toggle-chain next-state logic with a terminal-count wrap override.
module d_sync_counter
    import d_sync_counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int MODULUS  = 2**WIDTH,
    parameter bit COUNT_UP = UP
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] chain_src;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] d;
    logic             out_of_range;

    // Counting up a bit flips when all lower bits are 1; counting down, when all are 0.
    assign chain_src = COUNT_UP ? q : qbar;

    for (genvar i = 0; i < WIDTH; i++) begin : g_toggle
        if (i == 0) begin : g_lsb
            assign toggle[i] = 1'b1;
        end else begin : g_upper
            assign toggle[i] = &chain_src[i-1:0];
        end
    end

    assign out_of_range = ({1'b0, q} >= MOD_EXT);

    always_comb begin
        d = q ^ toggle;
        if (out_of_range) begin
            d = '0;
        end else if (COUNT_UP && (q == LAST)) begin
            d = '0;
        end else if (!COUNT_UP && (q == '0)) begin
            d = LAST;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ff
        d_ff u_ff (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (d[i]),
            .q    (q[i]),
            .qbar (qbar[i])
        );
    end

endmodule

// File: tb/tb_d_sync_counter.sv
// Bench for d_sync_counter: default up counter, modulus-10 up counter and
// down counter run side by side against modular-arithmetic reference counts.
module tb_d_sync_counter;
    import d_sync_counter_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [3:0] q_up, qb_up, q_m10, qb_m10, q_dn, qb_dn;

    int errors = 0;
    int checks = 0;

    // Reference counts: plain modular arithmetic per configuration.
    int m_up = 0;
    int m_10 = 0;
    int m_dn = 0;

    logic [3:0] aq [3];
    logic [3:0] aqb[3];
    int         em [3];

    always #5 clk = ~clk;

    d_sync_counter dut_up (
        .clk (clk),
        .rst_n(rst_n),
        .q   (q_up),
        .qbar(qb_up)
    );

    d_sync_counter #(.WIDTH(4), .MODULUS(10), .COUNT_UP(UP)) dut_m10 (
        .clk (clk),
        .rst_n(rst_n),
        .q   (q_m10),
        .qbar(qb_m10)
    );

    d_sync_counter #(.WIDTH(4), .MODULUS(16), .COUNT_UP(DOWN)) dut_dn (
        .clk (clk),
        .rst_n(rst_n),
        .q   (q_dn),
        .qbar(qb_dn)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_up <= 0;
            m_10 <= 0;
            m_dn <= 0;
        end else begin
            m_up <= (m_up + 1) % 16;
            m_10 <= (m_10 + 1) % 10;
            m_dn <= (m_dn + 16 - 1) % 16;
        end
    end

    always_comb begin
        aq[0]  = q_up;   aq[1]  = q_m10;  aq[2]  = q_dn;
        aqb[0] = qb_up;  aqb[1] = qb_m10; aqb[2] = qb_dn;
        em[0]  = m_up;   em[1]  = m_10;   em[2]  = m_dn;
    end

    task automatic hold_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] rel_exp[3];
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (aq[k] !== 4'h0 || aqb[k] !== 4'hF) begin
                    errors++;
                    $display("FAIL reset_hold[%0d]: q=%h qbar=%h, want q=0 qbar=F", k, aq[k], aqb[k]);
                end
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        rel_exp[0] = 4'h1; rel_exp[1] = 4'h1; rel_exp[2] = 4'hF;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (aq[k] !== rel_exp[k] || aqb[k] !== ~rel_exp[k]) begin
                errors++;
                $display("FAIL reset_release[%0d]: q=%h qbar=%h, want q=%h qbar=%h",
                         k, aq[k], aqb[k], rel_exp[k], ~rel_exp[k]);
            end
        end
    endtask

    task automatic test_count_run(input string name, input int cycles);
        hold_reset(1);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (aq[k] !== 4'(em[k]) || aqb[k] !== ~4'(em[k])) begin
                    errors++;
                    $display("FAIL %s[%0d] cyc %0d: q=%h qbar=%h, want q=%h qbar=%h",
                             name, k, c, aq[k], aqb[k], 4'(em[k]), ~4'(em[k]));
                end
            end
        end
    endtask

    task automatic test_down_start();
        logic [3:0] seq[4];
        seq[0] = 4'h0; seq[1] = 4'hF; seq[2] = 4'hE; seq[3] = 4'hD;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (q_dn !== seq[0] || qb_dn !== ~seq[0]) begin
            errors++;
            $display("FAIL down_seq 0: q=%h qbar=%h, want q=%h", q_dn, qb_dn, seq[0]);
        end
        rst_n = 1'b1;
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (q_dn !== seq[c] || qb_dn !== ~seq[c]) begin
                errors++;
                $display("FAIL down_seq %0d: q=%h qbar=%h, want q=%h", c, q_dn, qb_dn, seq[c]);
            end
        end
    endtask

    task automatic test_async_mid_count();
        int guard = 0;
        hold_reset(1);
        while (m_up != 9 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 40) begin
            errors++;
            $display("FAIL async_reach9: model stuck at %0d, want 9", m_up);
        end
        checks++;
        if (q_up !== 4'h9) begin
            errors++;
            $display("FAIL async_pre: q=%h, want 9", q_up);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (aq[k] !== 4'h0 || aqb[k] !== 4'hF) begin
                errors++;
                $display("FAIL async_clear[%0d]: q=%h qbar=%h, want q=0 qbar=F", k, aq[k], aqb[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (q_up !== 4'(c) || qb_up !== ~4'(c)) begin
                errors++;
                $display("FAIL async_resume %0d: q=%h qbar=%h, want q=%h", c, q_up, qb_up, 4'(c));
            end
        end
    endtask

    task automatic test_release_on_edge();
        int seen[16];
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        rst_n <= 1'b1;
        @(negedge clk);
        for (int v = 0; v < 16; v++) seen[v] = 0;
        seen[q_up]++;
        checks++;
        if (q_up !== 4'h0) begin
            errors++;
            $display("FAIL edge_release first: q=%h, want 0", q_up);
        end
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c < 16) seen[q_up]++;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (aq[k] !== 4'(em[k]) || aqb[k] !== ~4'(em[k])) begin
                    errors++;
                    $display("FAIL edge_release[%0d] cyc %0d: q=%h qbar=%h, want q=%h",
                             k, c, aq[k], aqb[k], 4'(em[k]));
                end
            end
        end
        checks++;
        if (q_up !== 4'h0) begin
            errors++;
            $display("FAIL edge_wrap_end: q=%h, want 0", q_up);
        end
        for (int v = 0; v < 16; v++) begin
            checks++;
            if (seen[v] != 1) begin
                errors++;
                $display("FAIL edge_coverage value %0d: seen %0d times, want 1", v, seen[v]);
            end
        end
    endtask

    task automatic test_random_resets();
        for (int it = 0; it < 10; it++) begin
            int run = $urandom_range(1, 30);
            for (int c = 0; c < run; c++) begin
                @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (aq[k] !== 4'(em[k]) || aqb[k] !== ~4'(em[k])) begin
                        errors++;
                        $display("FAIL random it %0d[%0d] cyc %0d: q=%h qbar=%h, want q=%h",
                                 it, k, c, aq[k], aqb[k], 4'(em[k]));
                    end
                end
            end
            #($urandom_range(1, 4));
            rst_n = 1'b0;
            #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (aq[k] !== 4'h0 || aqb[k] !== 4'hF) begin
                    errors++;
                    $display("FAIL random_clear it %0d[%0d]: q=%h qbar=%h, want q=0 qbar=F",
                             it, k, aq[k], aqb[k]);
                end
            end
            repeat ($urandom_range(1, 3)) @(negedge clk);
            #($urandom_range(1, 4));
            rst_n = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_count_run("default_20", 20);
        test_count_run("mod10_12", 12);
        test_down_start();
        test_async_mid_count();
        test_release_on_edge();
        test_random_resets();
        test_count_run("long_run", 40);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/d_sync_counter.md
# d_sync_counter

Free-running synchronous binary counter built from D flip-flops sharing one clock, with true (`q`) and complemented (`qbar`) state outputs. It is a standalone leaf block for counting and timing use and is the DUT of the counter verification environment. That environment drives it through interface `intf`, which carries `clk`, `rst_n`, `q` and `qbar`.

## Interface
Parameters:
- `WIDTH`, default 4: number of flip-flops, i.e. the counter width.
- `MODULUS`, default 2**WIDTH: count length; legal range 2..2**WIDTH.
- `COUNT_UP`, default 1: 1 = increment, 0 = decrement.

Ports:
- `clk`  input  1: the single clock; all state updates on its rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `q`  output  WIDTH: current count, taken directly from the flip-flop Q outputs.
- `qbar`  output  WIDTH: bitwise complement of `q`, taken from the flip-flop QBAR outputs.

## Operation
- Reset value: `q` = 0 and `qbar` = all ones ({WIDTH{1'b1}}), both for the full duration of reset.
- Up mode (`COUNT_UP`=1):
  - next = (q == MODULUS-1) ? 0 : q+1.
  - Default modulus: 0,1,…,15,0,…
- Down mode (`COUNT_UP`=0):
  - next = (q == 0) ? MODULUS-1 : q-1.
- Out-of-range state: if `q` ≥ MODULUS, the next state is 0 in both modes. This makes the counter self-correcting.
- Next-state logic:
  - Each bit's D input is its current value XOR the toggle term.
  - Up mode: the toggle term is the AND of all lower `q` bits.
  - Down mode: the toggle term is the AND of all lower `qbar` bits.
  - The terminal-count override forces all D inputs to the wrap value.
- All flip-flops are clocked by `clk` only, with no ripple clocking.
- Invariant: `qbar` == ~`q` at all times, including during reset and at wrap.
- There is no enable or load input; the counter advances on every rising clock edge while `rst_n` is high.

## Timing
- Latency: one clock. `q` takes its next value at the rising edge after the current value was presented.
- The first increment after reset release occurs on the first rising edge at which `rst_n` is sampled high.
- Reset assertion clears `q` (and sets `qbar`) immediately, without waiting for a clock edge. This holds mid-count as well.
- A rising edge that coincides with `rst_n` low has no effect; reset dominates.
- Wrap from MODULUS-1 to 0 (or 0 to MODULUS-1 in down mode) is a single ordinary clock step, with no extra cycle.
- All bits change on the same edge; outputs are registered and glitch-free.

## Structure
- Sub-module `d_ff`:
  - Ports: `clk`, `rst_n`, `d`, `q`, `qbar`.
  - Asynchronous active-low reset to `q`=0.
  - `qbar` = ~`q`.
- The top level instantiates WIDTH copies of `d_ff` via a generate loop and contains the combinational toggle/wrap logic.
- Shared package `d_sync_counter_pkg`:
  - Default WIDTH constant.
  - Count-direction constants UP = 1, DOWN = 0.

## Test plan
- Assert `rst_n`=0 for 2 cycles → `q`=4'h0 and `qbar`=4'hF throughout; release → `q`=1 after the first edge.
- Default parameters, 20 clocks after reset → `q` runs 0..15, then 0,1,2,3; `qbar`==~`q` on every cycle.
- Reset pulsed asynchronously between edges while `q`=4'h9 → `q`=0 and `qbar`=4'hF immediately; counting resumes 1,2,… after release.
- `MODULUS`=10, 12 clocks → `q` runs 0..9, then 0,1.
- `COUNT_UP`=0, 3 clocks after reset → `q` runs 0, 15, 14, 13.
- `rst_n` released coincident with a rising edge, then 16 clocks → exactly one full wrap with no skipped or duplicated values.
